// File: rtl/inmem_pingpong_streamer.sv
// inmem_pingpong_streamer: double-buffered banked row store; the host fills one half
// while the other half streams out as row-wide beats through a 2-entry output FIFO.
module inmem_pingpong_streamer #(
    parameter int NUM_BANKS = 8,
    parameter int ROWS      = 64,
    parameter int WPR       = 8,
    localparam int RA_W = $clog2(ROWS),
    localparam int BA_W = $clog2(NUM_BANKS),
    localparam int WA_W = $clog2(WPR),
    localparam int HA_W = BA_W + RA_W + WA_W,
    localparam int DW   = NUM_BANKS * WPR * 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            host_en,
    input  logic [3:0]      host_we,
    input  logic [HA_W-1:0] host_addr,
    input  logic [31:0]     host_din,
    output logic [31:0]     host_dout,
    input  logic            host_commit,
    output logic            host_busy,
    input  logic            rd_start,
    input  logic [RA_W-1:0] rd_base,
    input  logic [RA_W:0]   rd_len,
    input  logic            rd_release,
    output logic            rd_loaded,
    output logic            rd_busy,
    output logic            rd_err,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [DW-1:0]   m_data,
    output logic            m_last
);
    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_e;
    state_e state_q, state_d;
    logic [31:0] mem_q [2][NUM_BANKS][ROWS][WPR];
    logic [BA_W-1:0] h_bank;
    logic [RA_W-1:0] h_row;
    logic [WA_W-1:0] h_word;
    logic [31:0] h_old, h_new, host_dout_q;
    logic fill_sel_q, fill_sel_d, loaded_q, loaded_d, hbusy_q, hbusy_d, err_q, err_d;
    logic [RA_W-1:0] row_q, row_d;
    logic [RA_W:0] left_q, left_d;
    logic [DW-1:0] rd_row, rdata_q;
    logic infl_q, infl_last_q;
    logic [DW:0] e0_q, e0_d, e1_q, e1_d;
    logic [1:0] cnt_q, cnt_d;
    logic [2:0] occ;
    logic start_ok, rel_ok, pop, push, issue, last_issue;

    assign {h_bank, h_row, h_word} = host_addr;
    assign h_old = mem_q[fill_sel_q][h_bank][h_row][h_word];
    assign h_new = {host_we[3] ? host_din[31:24] : h_old[31:24],
                    host_we[2] ? host_din[23:16] : h_old[23:16],
                    host_we[1] ? host_din[15:8]  : h_old[15:8],
                    host_we[0] ? host_din[7:0]   : h_old[7:0]};

    // Bank 0 lands in the most significant slice, word 0 at the bottom of each slice.
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        for (genvar w = 0; w < WPR; w++) begin : g_word
            assign rd_row[(NUM_BANKS-1-b)*WPR*32 + w*32 +: 32] = mem_q[~fill_sel_q][b][row_q][w];
        end
    end

    assign m_valid    = cnt_q != 2'd0;
    assign m_data     = e0_q[DW-1:0];
    assign m_last     = m_valid & e0_q[DW];
    assign pop        = m_valid & m_ready;
    assign push       = infl_q;
    // Occupancy after this cycle's push/pop; a read is issued only if its result will fit.
    assign occ        = {1'b0, cnt_q} + {2'b0, infl_q} - {2'b0, pop};
    assign issue      = state_q == RUN && occ < 3'd2;
    assign last_issue = issue && left_q == (RA_W+1)'(1);
    assign start_ok   = rd_start && loaded_q && state_q == IDLE && rd_len != '0;
    assign rel_ok     = rd_release && loaded_q && state_q == IDLE;
    assign host_dout  = host_dout_q;
    assign host_busy  = hbusy_q;
    assign rd_loaded  = loaded_q;
    assign rd_busy    = state_q != IDLE;
    assign rd_err     = err_q;

    always_comb begin
        fill_sel_d = fill_sel_q;
        loaded_d   = loaded_q;
        hbusy_d    = hbusy_q;
        err_d      = err_q | (rd_release & ~rel_ok) | (rd_start & ~start_ok);
        if (rel_ok) begin
            fill_sel_d = fill_sel_q ^ (hbusy_q | host_commit);
            loaded_d   = hbusy_q | host_commit;
            hbusy_d    = 1'b0;
        end else if (host_commit && !hbusy_q) begin
            fill_sel_d = fill_sel_q ^ ~loaded_q;
            loaded_d   = 1'b1;
            hbusy_d    = loaded_q;
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        left_d  = left_q;
        case (state_q)
            IDLE: if (start_ok) begin
                state_d = RUN;
                row_d   = rd_base;
                left_d  = rd_len;
            end
            RUN: if (issue) begin
                row_d   = row_q + 1'b1;
                left_d  = left_q - 1'b1;
                state_d = last_issue ? FLUSH : RUN;
            end
            FLUSH: state_d = (pop && e0_q[DW]) ? IDLE : FLUSH;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
        e0_d  = (push && (cnt_q == 2'd0 || (pop && cnt_q == 2'd1))) ? {infl_last_q, rdata_q} :
                pop ? e1_q : e0_q;
        e1_d  = (push && cnt_q == (pop ? 2'd2 : 2'd1)) ? {infl_last_q, rdata_q} : e1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            fill_sel_q  <= 1'b0;
            loaded_q    <= 1'b0;
            hbusy_q     <= 1'b0;
            err_q       <= 1'b0;
            row_q       <= '0;
            left_q      <= '0;
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
            e0_q        <= '0;
            e1_q        <= '0;
            cnt_q       <= 2'd0;
            host_dout_q <= '0;
        end else begin
            state_q     <= state_d;
            fill_sel_q  <= fill_sel_d;
            loaded_q    <= loaded_d;
            hbusy_q     <= hbusy_d;
            err_q       <= err_d;
            row_q       <= row_d;
            left_q      <= left_d;
            infl_q      <= issue;
            infl_last_q <= last_issue;
            e0_q        <= e0_d;
            e1_q        <= e1_d;
            cnt_q       <= cnt_d;
            if (host_en) host_dout_q <= h_old;
        end
    end

    // Storage and its read register are not reset; in-flight tracking above gates their use.
    always_ff @(posedge clk) begin
        if (host_en && |host_we) mem_q[fill_sel_q][h_bank][h_row][h_word] <= h_new;
        if (issue) rdata_q <= rd_row;
    end
endmodule

// File: doc/inmem_pingpong_streamer.md
INMEM_PINGPONG_STREAMER -- requirements
Module: inmem_pingpong_streamer

Interface
REQ-001 The block SHALL have parameter NUM_BANKS, default 8, number of memory banks (power of 2).
REQ-002 The block SHALL have parameter ROWS, default 64, rows per buffer half (power of 2).
REQ-003 The block SHALL have parameter WPR, default 8, 32-bit words per bank row (power of 2).
REQ-004 Derived widths SHALL be: RA_W=clog2(ROWS), HA_W=clog2(NUM_BANKS)+RA_W+clog2(WPR), DW=NUM_BANKS*WPR*32.
REQ-005 The block SHALL use one clock and an asynchronous, active-low reset: clk in 1 (all logic on rising edge); rst_n in 1 (async assert, sync deassert).
REQ-006 Host-side ports SHALL be:
- host_en in 1: host access enable.
- host_we in 4: byte write enables.
- host_addr in HA_W: {bank, row, word}.
- host_din in 32: write data.
- host_dout out 32: read data.
- host_commit in 1: fill buffer complete.
- host_busy out 1: commit pending.
REQ-007 Read-side control ports SHALL be:
- rd_start in 1: start stream.
- rd_base in RA_W: first row.
- rd_len in RA_W+1: row count.
- rd_release in 1: drain buffer consumed.
- rd_loaded out 1: drain buffer valid.
- rd_busy out 1: stream active.
- rd_err out 1: sticky protocol error.
REQ-008 Stream ports SHALL be:
- m_valid out 1.
- m_ready in 1.
- m_data out DW: bank 0 in MSB slice; word 0 in LSBs of each bank slice.
- m_last out 1: final row of stream.

Function
REQ-009 Storage SHALL be two halves (fill, drain), each NUM_BANKS x ROWS x WPR words; fill_sel selects the host-owned half.
REQ-010 Host access SHALL target only the fill half:
- host_en with any host_we bit set writes the selected bytes.
- host_dout returns the addressed word one cycle after host_en, and holds otherwise.
REQ-011 host_commit SHALL act as follows:
- rd_loaded=0: toggle fill_sel and set rd_loaded the next cycle.
- rd_loaded=1: set host_busy until the swap occurs.
- Commit while host_busy=1: ignored.
REQ-012 rd_release SHALL act as follows:
- rd_loaded=1 and rd_busy=0: clear rd_loaded; a pending commit swaps in the same cycle and rd_loaded stays 1.
- Otherwise: ignored and set rd_err.
REQ-013 A host access in the cycle of a swap SHALL use the pre-swap fill_sel.
REQ-014 rd_start SHALL be accepted only when rd_loaded=1, rd_busy=0 and rd_len!=0; otherwise it SHALL be ignored and rd_err set.
REQ-015 The read FSM SHALL have states IDLE, RUN and FLUSH:
- IDLE->RUN on an accepted start.
- RUN->FLUSH after the last row read is issued.
- FLUSH->IDLE when the output buffer empties after the m_last beat is accepted.
- rd_busy=1 in RUN and FLUSH.
REQ-016 Row addresses SHALL be (rd_base+i) mod ROWS for i=0..rd_len-1; wrap-around is legal; rd_len=ROWS streams the whole half.
REQ-017 Memory read latency SHALL be 1 cycle, and data SHALL pass through a 2-entry output FIFO.
REQ-018 A row read SHALL be issued only if FIFO occupancy plus in-flight reads is less than 2; no beat SHALL ever be dropped or duplicated.
REQ-019 With start sampled at edge T, the first m_valid SHALL be high after edge T+2; with m_ready held at 1, the block SHALL sustain one row per cycle.
REQ-020 m_data and m_last SHALL stay stable while m_valid=1 and m_ready=0.
REQ-021 m_last SHALL be asserted only on the beat for i=rd_len-1.

Reset
REQ-022 While rst_n=0, the block SHALL hold: m_valid=0, m_last=0, m_data=0, host_dout=0, host_busy=0, rd_loaded=0, rd_busy=0, rd_err=0, fill_sel=0, FSM=IDLE, FIFO empty.
REQ-023 Memory contents SHALL NOT be reset; a reset mid-stream SHALL abort the stream with no further beats.

Verification
REQ-024 The bench SHALL cover basic stream:
- Stimulus: write row r of bank b word w = {b,r,w}, commit, rd_start base=0 len=4, m_ready=1.
- Response: 4 beats in consecutive cycles from T+2, matching data, m_last on beat 4.
REQ-025 The bench SHALL cover wrap-around: base=62, len=4 (ROWS=64) -> rows 62,63,0,1 in order.
REQ-026 The bench SHALL cover backpressure: m_ready toggled 1,0,0,1 pseudo-randomly over len=16 -> 16 beats in order, data stable while stalled, none lost.
REQ-027 The bench SHALL cover ping-pong:
- Stimulus: commit A; fill B; commit -> host_busy=1; release.
- Response: in the same cycle, swap, rd_loaded stays 1, host_busy=0, and the stream reads B data.
REQ-028 The bench SHALL cover errors: rd_start with rd_loaded=0, with len=0, and rd_release while rd_busy=1 -> each is ignored and rd_err=1 stays until reset.
REQ-029 The bench SHALL cover reset mid-stream: rst_n low at beat 3 of len=8 -> all outputs at reset values; after release, a new stream requires a fresh commit.
